// File: rtl/cbus_arbiter_pkg.sv
// Local definitions for the CBus round-robin arbiter.
package cbus_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/common.sv
// Shared CBus types used by every bus adapter, cache and bridge in the system.
package common;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef enum logic [3:0] {
    MLEN1  = 4'd0,
    MLEN2  = 4'd1,
    MLEN4  = 4'd3,
    MLEN8  = 4'd7,
    MLEN16 = 4'd15
  } mlen_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    mlen_t       len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

// File: rtl/cbus_arbiter_rr_select.sv
// Combinational round-robin picker: first valid port after `last`, modulo N.
module rr_select #(
  parameter  int unsigned N  = 2,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] last,
  output logic          found,
  output logic [IW-1:0] pick
);

  always_comb begin
    int unsigned cand;
    found = 1'b0;
    pick  = '0;
    cand  = 0;
    // Scan last+1 .. last+N so `last` itself has the lowest priority.
    for (int unsigned k = 1; k <= N; k++) begin
      cand = (32'(last) + k) % N;
      if (!found && valid[IW'(cand)]) begin
        found = 1'b1;
        pick  = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/cbus_arbiter.sv
// Round-robin CBus arbiter: one master at a time, grant held until its burst ends.
module cbus_arbiter
  import common::*;
  import cbus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 2
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  cbus_req_t  [NUM_INPUTS-1:0]  ireqs,
  output cbus_resp_t [NUM_INPUTS-1:0]  iresps,
  output cbus_req_t                    oreq,
  input  cbus_resp_t                   oresp
);

  localparam int unsigned IW = $clog2(NUM_INPUTS);

  arb_state_t          state;
  logic [IW-1:0]       index;
  logic [IW-1:0]       last_grant;
  logic [NUM_INPUTS-1:0] valids;
  logic                found;
  logic [IW-1:0]       pick;

  always_comb begin
    valids = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      valids[i] = ireqs[i].valid;
    end
  end

  rr_select #(
    .N(NUM_INPUTS)
  ) u_rr_select (
    .valid(valids),
    .last (last_grant),
    .found(found),
    .pick (pick)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      index      <= '0;
      last_grant <= IW'(NUM_INPUTS - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            state <= ST_BUSY;
            index <= pick;
          end
        end
        ST_BUSY: begin
          // Withdrawn or competing requests are ignored; only last ends the grant.
          if (oresp.ready && oresp.last) begin
            state      <= ST_IDLE;
            last_grant <= index;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    oreq   = '0;
    iresps = '0;
    if (state == ST_BUSY) begin
      oreq          = ireqs[index];
      iresps[index] = oresp;
    end
  end

endmodule

// File: doc/cbus_arbiter.md
# cbus_arbiter

Multiplexes `NUM_INPUTS` CBus masters onto one CBus slave port. Typical masters are the instruction-side and data-side bus adapters or caches, and the slave is the memory/AXI bridge. It grants one master at a time with round-robin priority and holds the grant until that master's burst completes. Only the granted master sees slave responses.

## Interface
- `NUM_INPUTS`, default 2: number of CBus masters, ≥ 2. Index width `IW = $clog2(NUM_INPUTS)`.
- `clk`, input, 1: the single clock.
- `resetn`, input, 1: synchronous reset, active low. Sampled on the rising edge of `clk`.
- `ireqs`, input, `cbus_req_t [NUM_INPUTS-1:0]`: requests from the masters.
- `iresps`, output, `cbus_resp_t [NUM_INPUTS-1:0]`: responses to the masters.
- `oreq`, output, `cbus_req_t`: request to the shared slave.
- `oresp`, input, `cbus_resp_t`: response from the shared slave.

## Operation
- Internal state:
  - `busy`: 1 bit.
  - `index`: IW bits, the granted master.
  - `last_grant`: IW bits, the round-robin pointer.
- States:
  - IDLE (`busy=0`): `oreq` is all-zero and every `iresps[i]` is all-zero.
  - BUSY (`busy=1`): `oreq = ireqs[index]` (combinational pass-through) and `iresps[index] = oresp`. All other `iresps[j]` are all-zero.
- IDLE → BUSY:
  - Taken at the first edge where any `ireqs[i].valid=1`.
  - `index` gets the first valid port, scanning `last_grant+1, last_grant+2, …` modulo `NUM_INPUTS`.
- BUSY → IDLE:
  - Taken at the edge where `oresp.ready && oresp.last`.
  - `last_grant <= index`.
- In BUSY the arbiter ignores every other request, whether new or withdrawn. The grant is never preempted.
- Masters hold `valid` and the payload stable until their `ready && last`, per the CBus rule. If a granted master drops `valid` mid-burst, that is a protocol violation. The arbiter keeps `index` and stays BUSY until `last` arrives. There is no abort.
- The arbiter never modifies the payload. `is_write`, `size`, `addr`, `strobe`, `data` and `len` pass through unchanged.

## Timing
- Reset values (cycle after `resetn` is low at an edge):
  - `busy=0` and `index=0`.
  - `last_grant = NUM_INPUTS-1`, so port 0 has top priority first.
  - `oreq` and all `iresps` are zero.
- Grant latency: a request first valid in cycle t appears on `oreq` in cycle t+1, provided the arbiter was IDLE in cycle t.
- Completion: if `ready && last` occurs in cycle t, the arbiter is IDLE in cycle t+1 and the next grant is visible in cycle t+2.
  - This gives exactly one bubble cycle between back-to-back bursts, even from the same master.
- `iresps[index]` reflects `oresp` in the same cycle, with no added latency on `ready`, `last` or `data`.
- Simultaneous requests in IDLE: resolved only by the round-robin scan. There is no fixed priority beyond the pointer.
- Wrap-around: the pointer scan is modulo `NUM_INPUTS`.
  - For a non-power-of-two `NUM_INPUTS`, indices ≥ `NUM_INPUTS` are never selected.
- Reset mid-burst: state returns to reset values at that edge. `oreq.valid=0` from the next cycle. The slave must be reset together with the arbiter.
- Single-beat transfers (`len=MLEN1`): `last` is asserted with the first `ready`, so the burst occupies exactly one BUSY cycle once the slave responds.

## Structure
- Types `cbus_req_t` and `cbus_resp_t` and the `MLEN*` length encodings already live in `common`. Nothing new is added there.
- One sub-module, `rr_select #(N)`:
  - Inputs: `valid[N-1:0]`, `last[IW-1:0]`.
  - Outputs: `found`, `pick[IW-1:0]`.
  - Purely combinational. Reused later by other arbiters.
- The top level holds the `busy`/`index`/`last_grant` registers and the output muxing.

## Test plan
- **Reset, single master:** reset, then port 0 `valid=1`, `addr=32'h1000`, `len=MLEN1`; slave responds `ready=last=1`, `data=32'hdeadbeef` one cycle after `oreq.valid`.
  - `oreq.addr=32'h1000` from cycle 1.
  - `iresps[0].data=32'hdeadbeef` with `ready=1`.
  - `iresps[1]` stays zero.
- **Simultaneous requests:** both ports valid at reset release.
  - Port 0 is granted first, then port 1 after one IDLE bubble.
  - With both held valid, grants alternate 0,1,0,1.
- **Burst hold:** port 1 issues `len=MLEN4`; port 0 asserts valid during beat 2.
  - `oreq` tracks port 1 for all 4 beats.
  - Port 0 is granted only in the cycle after the IDLE cycle that follows beat 4.
- **Busy isolation:** while port 0 is granted, the slave asserts `ready` for non-last beats.
  - `iresps[1].ready` stays 0 throughout.
- **Reset mid-burst:** deassert `resetn` during beat 2 of a 4-beat burst.
  - Next cycle `oreq.valid=0` and `busy=0`.
  - After release, port 0 wins the first simultaneous request.
- **NUM_INPUTS=3 wrap:** `last_grant=2`, ports 1 and 2 valid → port 1 granted.
